// File: rtl/pll_sup_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
// State encoding is visible on state_o, so the enum values are fixed.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST   = 3'd0,
        ST_WAITLOCK = 3'd1,
        ST_STABLE   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FATAL    = 3'd4
    } state_e;

    localparam int RETRY_W = 3;
    localparam int LOSS_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold values 0..n-1.
    function automatic int width_for(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/pll_sup_if.sv
// PLL-side and reset-tree signals of the lock supervisor.
// hb_fail exists only when PLL_SUPERVISOR_HEARTBEAT_EN is defined.
interface pll_sup_if;
    import pll_sup_pkg::*;

    logic              pll_locked;
    logic              pll_heartbeat;
    logic              pll_rst;
    logic              sys_reset_n;
    logic              fatal;
    logic [RETRY_W-1:0] retry_cnt;
    logic [LOSS_W-1:0]  loss_cnt;
    logic [2:0]        state_o;
`ifdef PLL_SUPERVISOR_HEARTBEAT_EN
    logic              hb_fail;

    modport master (
        input  pll_locked, pll_heartbeat,
        output pll_rst, sys_reset_n, fatal,
        output retry_cnt, loss_cnt, state_o, hb_fail
    );
    modport slave (
        output pll_locked, pll_heartbeat,
        input  pll_rst, sys_reset_n, fatal,
        input  retry_cnt, loss_cnt, state_o, hb_fail
    );
`else
    modport master (
        input  pll_locked, pll_heartbeat,
        output pll_rst, sys_reset_n, fatal,
        output retry_cnt, loss_cnt, state_o
    );
    modport slave (
        output pll_locked, pll_heartbeat,
        input  pll_rst, sys_reset_n, fatal,
        input  retry_cnt, loss_cnt, state_o
    );
`endif
endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer with async active-low reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer / lock qualifier driving the core reset tree.
// Define PLL_SUPERVISOR_HEARTBEAT_EN to add the RUN-state heartbeat check.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STABLE_CYCLES  = 65536,
    parameter int MAX_RETRIES    = 7,
    parameter int HB_WINDOW      = 1024,
    parameter int HB_MIN         = 32,
    parameter int HB_MAX         = 40
) (
    input  logic      clk,
    input  logic      rst_n,
    pll_sup_if.master bus
);
    localparam int CW = width_for(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               srst_n_q, srst_n_d;
    logic               lock;
    logic               hb_bad;
    logic               fail;

    sync2 #(.W(1)) u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lock)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_PLLRST;
            cnt_q    <= '0;
            retry_q  <= '0;
            loss_q   <= '0;
            srst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            srst_n_q <= srst_n_d;
        end
    end

    // cnt counts cycles spent in the current timed state, cleared on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        fail    = 1'b0;
        unique case (state_q)
            ST_PLLRST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) state_d = ST_WAITLOCK;
            end
            ST_WAITLOCK: begin
                cnt_d = cnt_q + 1'b1;
                if (lock) state_d = ST_STABLE;
                else if (cnt_q == TO_LAST) fail = 1'b1;
            end
            ST_STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (!lock) fail = 1'b1;
                else if (cnt_q == STB_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock || hb_bad) begin
                    state_d = ST_PLLRST;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            ST_FATAL: ;
            default: state_d = ST_FATAL;
        endcase
        if (fail) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FATAL;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = ST_PLLRST;
            end
        end
        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;
        if (state_d != state_q) cnt_d = '0;
        srst_n_d = (state_q == ST_RUN) && lock && !hb_bad;
    end

    assign bus.pll_rst     = (state_q == ST_PLLRST) || (state_q == ST_FATAL);
    assign bus.sys_reset_n = srst_n_q;
    assign bus.fatal       = (state_q == ST_FATAL);
    assign bus.retry_cnt   = retry_q;
    assign bus.loss_cnt    = loss_q;
    assign bus.state_o     = state_q;

`ifdef PLL_SUPERVISOR_HEARTBEAT_EN
    localparam int WW = width_for(HB_WINDOW);
    localparam int EW = width_for(HB_WINDOW + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(HB_WINDOW - 1);
    localparam logic [EW-1:0] E_MIN    = EW'(HB_MIN);
    localparam logic [EW-1:0] E_MAX    = EW'(HB_MAX);

    logic          hb_s, hb_dly_q, hb_dly_d, hb_edge, win_end;
    logic          hb_fail_q, hb_fail_d;
    logic [WW-1:0] win_q, win_d;
    logic [EW-1:0] edg_q, edg_d, edg_tot;

    sync2 #(.W(1)) u_sync_hb (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_heartbeat),
        .q     (hb_s)
    );

    assign hb_edge = hb_s ^ hb_dly_q;
    assign edg_tot = edg_q + EW'(hb_edge);
    assign win_end = (win_q == WIN_LAST);
    assign hb_bad  = (state_q == ST_RUN) && win_end &&
                     ((edg_tot < E_MIN) || (edg_tot > E_MAX));

    always_comb begin
        hb_dly_d  = hb_s;
        hb_fail_d = hb_fail_q | hb_bad;
        win_d     = '0;
        edg_d     = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && !win_end) begin
            win_d = win_q + 1'b1;
            edg_d = edg_tot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_dly_q  <= 1'b0;
            hb_fail_q <= 1'b0;
            win_q     <= '0;
            edg_q     <= '0;
        end else begin
            hb_dly_q  <= hb_dly_d;
            hb_fail_q <= hb_fail_d;
            win_q     <= win_d;
            edg_q     <= edg_d;
        end
    end

    assign bus.hb_fail = hb_fail_q;
`else
    logic unused_hb;
    assign unused_hb = bus.pll_heartbeat;
    assign hb_bad    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised bench for pll_lock_supervisor with a cycle-level reference model.
// Heartbeat checks compile in when PLL_SUPERVISOR_HEARTBEAT_EN is defined.
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 20;
    localparam int P_STB  = 8;
    localparam int P_MAXR = 7;
    localparam int P_HBW  = 1024;
    localparam int P_HMIN = 32;
    localparam int P_HMAX = 40;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   hb_period = 28;

    pll_sup_if bus();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_STB),
        .MAX_RETRIES    (P_MAXR),
        .HB_WINDOW      (P_HBW),
        .HB_MIN         (P_HMIN),
        .HB_MAX         (P_HMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.pll_heartbeat = 1'b0;
        forever begin
            repeat (hb_period) @(posedge clk);
            #1 bus.pll_heartbeat = ~bus.pll_heartbeat;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: states numbered as on state_o, time measured in cycles.
    int m_state, m_time, m_retry, m_loss, m_win, m_edges;
    bit m_srst, m_hbf;
    bit lk_h[3];
    bit hb_h[3];

    task automatic model_reset();
        m_state = 0; m_time = 0; m_retry = 0; m_loss = 0;
        m_win = 0; m_edges = 0; m_srst = 0; m_hbf = 0;
        for (int i = 0; i < 3; i++) begin
            lk_h[i] = 0;
            hb_h[i] = 0;
        end
    endtask

    task automatic model_step();
        bit lock, hbad, fail;
        int nxt;
        lock = lk_h[1];
        hbad = 0;
        fail = 0;
        nxt  = m_state;
`ifdef PLL_SUPERVISOR_HEARTBEAT_EN
        if (m_state == 3) begin
            if (hb_h[1] != hb_h[2]) m_edges++;
            m_win++;
            if (m_win == P_HBW) begin
                hbad = (m_edges < P_HMIN) || (m_edges > P_HMAX);
                m_win = 0;
                m_edges = 0;
            end
        end
`endif
        case (m_state)
            0: if (m_time + 1 == P_RST) nxt = 1;
            1: if (lock) nxt = 2; else if (m_time + 1 == P_TO) fail = 1;
            2: if (!lock) fail = 1; else if (m_time + 1 == P_STB) nxt = 3;
            3: if (!lock || hbad) begin
                   nxt = 0;
                   if (m_loss < 255) m_loss++;
               end
            default: ;
        endcase
        m_srst = (m_state == 3) && lock && !hbad;
        if (hbad) m_hbf = 1;
        if (fail) begin
            if (m_retry == P_MAXR) nxt = 4;
            else begin
                m_retry++;
                nxt = 0;
            end
        end
        if (nxt == 3 && m_state != 3) m_retry = 0;
        if (nxt != m_state) begin
            m_time = 0;
            m_win = 0;
            m_edges = 0;
        end else begin
            m_time++;
        end
        m_state = nxt;
        lk_h[2] = lk_h[1]; lk_h[1] = lk_h[0]; lk_h[0] = bus.pll_locked;
        hb_h[2] = hb_h[1]; hb_h[1] = hb_h[0]; hb_h[0] = bus.pll_heartbeat;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("m_state", bus.state_o, m_state);
        chk("m_pll_rst", bus.pll_rst, (m_state == 0 || m_state == 4));
        chk("m_sys_reset_n", bus.sys_reset_n, m_srst);
        chk("m_fatal", bus.fatal, (m_state == 4));
        chk("m_retry_cnt", bus.retry_cnt, m_retry);
        chk("m_loss_cnt", bus.loss_cnt, m_loss);
`ifdef PLL_SUPERVISOR_HEARTBEAT_EN
        chk("m_hb_fail", bus.hb_fail, m_hbf);
`endif
    end

    task automatic wait_state(input int st, input int maxc, input string nm);
        int n;
        n = 0;
        while (int'(bus.state_o) != st && n < maxc) begin
            tick();
            n++;
        end
        if (int'(bus.state_o) != st) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, state_o=%0d expected %0d", nm, bus.state_o, st);
        end
    endtask

    task automatic wait_srst(input bit v, input int maxc, input string nm);
        int n;
        n = 0;
        while (bus.sys_reset_n != v && n < maxc) begin
            tick();
            n++;
        end
        if (bus.sys_reset_n != v) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, sys_reset_n=%0d expected %0d", nm, bus.sys_reset_n, v);
        end
    endtask

    task automatic do_reset(input bit lk);
        rst_n = 1'b0;
        bus.pll_locked = lk;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, bus.state_o, 0);
        chk({tag, "_pll_rst"}, bus.pll_rst, 1);
        chk({tag, "_sys_reset_n"}, bus.sys_reset_n, 0);
        chk({tag, "_fatal"}, bus.fatal, 0);
        chk({tag, "_retry"}, bus.retry_cnt, 0);
        chk({tag, "_loss"}, bus.loss_cnt, 0);
    endtask

    initial begin
        int n, prev;
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");

        // Nominal lock
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.pll_rst) break;
            n++;
        end
        chk("pll_rst_width", n, P_RST);
        repeat (10) tick();
        bus.pll_locked = 1'b1;
        tick();
        n = 0;
        while (!bus.sys_reset_n && n < 200) begin
            tick();
            n++;
        end
        chk("release_latency", n, 2 + P_STB + 1);
        chk("nominal_state", bus.state_o, 3);
        chk("nominal_retry", bus.retry_cnt, 0);

        // Glitch in STABLE
        do_reset(1'b1);
        wait_state(2, 100, "glitch_reach_stable");
        repeat (2) tick();
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        wait_state(0, 10, "glitch_back_pllrst");
        chk("glitch_retry", bus.retry_cnt, 1);
        chk("glitch_srst", bus.sys_reset_n, 0);
        wait_srst(1'b1, 200, "glitch_relock");
        chk("glitch_retry_cleared", bus.retry_cnt, 0);

        // Three losses in RUN
        do_reset(1'b1);
        wait_srst(1'b1, 200, "loss_first_lock");
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 20)) tick();
            bus.pll_locked = 1'b0;
            n = 0;
            while (bus.sys_reset_n && n < 10) begin
                tick();
                n++;
            end
            chk("loss_fall_within3", (n >= 1 && n <= 3), 1);
            repeat ($urandom_range(0, 4)) tick();
            bus.pll_locked = 1'b1;
            wait_srst(1'b1, 200, "loss_relock");
            chk("loss_cnt", bus.loss_cnt, i + 1);
            chk("loss_retry", bus.retry_cnt, 0);
            chk("loss_fatal", bus.fatal, 0);
        end

        // Async reset mid-STABLE
        do_reset(1'b1);
        wait_state(2, 100, "arst_reach_stable");
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        rst_n = 1'b1;
        wait_srst(1'b1, 200, "arst_restart");
        chk("arst_run", bus.state_o, 3);

        // Lock timeout to FATAL
        do_reset(1'b0);
        prev = 0;
        for (int i = 0; i < 400 && !bus.fatal; i++) begin
            tick();
            if (int'(bus.retry_cnt) != prev) begin
                chk("retry_step", bus.retry_cnt, prev + 1);
                prev = int'(bus.retry_cnt);
            end
        end
        chk("retry_final", prev, P_MAXR);
        chk("fatal_state", bus.state_o, 4);
        chk("fatal_flag", bus.fatal, 1);
        chk("fatal_pll_rst", bus.pll_rst, 1);
        chk("fatal_srst", bus.sys_reset_n, 0);
        bus.pll_locked = 1'b1;
        repeat (50) tick();
        chk("fatal_hold_state", bus.state_o, 4);
        chk("fatal_hold_srst", bus.sys_reset_n, 0);

`ifdef PLL_SUPERVISOR_HEARTBEAT_EN
        hb_period = 28;
        do_reset(1'b1);
        wait_srst(1'b1, 200, "hb_lock");
        repeat (3000) tick();
        chk("hb_ok_state", bus.state_o, 3);
        chk("hb_ok_loss", bus.loss_cnt, 0);
        chk("hb_ok_fail", bus.hb_fail, 0);
        hb_period = 51;
        wait_state(0, 3500, "hb_slow_drop");
        chk("hb_slow_fail", bus.hb_fail, 1);
        chk("hb_slow_loss", bus.loss_cnt, 1);
        chk("hb_slow_srst", bus.sys_reset_n, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
